scytale_codec: RTL and testbench

//  Parametrised successor to the scytale decryption stage: a run-time

---
 rtl/scytale_codec_if.sv | 26 ++
 rtl/scytale_codec.sv | 159 +++++++++++++++
 tb/tb_scytale_codec.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/scytale_codec_if.sv
// Character-stream bus between the byte front end and the scytale codec.
// The master drives characters and keys; the slave returns the permuted stream.
interface scytale_codec_if #(
  parameter int D_WIDTH   = 8,
  parameter int KEY_WIDTH = 8
);
  logic [D_WIDTH-1:0]   data_i;
  logic                 valid_i;
  logic                 mode_i;
  logic [KEY_WIDTH-1:0] key_N;
  logic [KEY_WIDTH-1:0] key_M;
  logic                 busy;
  logic [D_WIDTH-1:0]   data_o;
  logic                 valid_o;
  logic                 err_o;

  modport master (
    output data_i, valid_i, mode_i, key_N, key_M,
    input  busy, data_o, valid_o, err_o
  );

  modport slave (
    input  data_i, valid_i, mode_i, key_N, key_M,
    output busy, data_o, valid_o, err_o
  );
endinterface

// File: rtl/scytale_codec.sv
// Run-time selectable scytale encrypt/decrypt engine: buffers a message up to
// a terminator token, then streams the transposed message one char per cycle.
module scytale_codec #(
  parameter int                 D_WIDTH       = 8,
  parameter int                 KEY_WIDTH     = 8,
  parameter int                 MAX_NOF_CHARS = 50,
  parameter logic [D_WIDTH-1:0] START_TOKEN   = 8'hFA
) (
  input logic            clk,
  input logic            rst,
  scytale_codec_if.slave bus
);
  localparam int PTR_W = $clog2(MAX_NOF_CHARS + 1);
  localparam int LEN_W = 2 * KEY_WIDTH;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef enum logic {S_LOAD, S_OUT} state_t;

  state_t             state_q, state_d;
  ptr_t               wr_ptr_q, wr_ptr_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic [D_WIDTH-1:0] data_q, data_d;
  ptr_t               inner_q, inner_d;
  ptr_t               outer_q, outer_d;
  ptr_t               base_q, base_d;
  ptr_t               stride_q, stride_d;
  ptr_t               inner_last_q, inner_last_d;
  ptr_t               outer_last_q, outer_last_d;

  logic               wr_en;
  logic               rd_en;
  ptr_t               rd_idx;
  logic [LEN_W-1:0]   msg_len;
  logic               reject;

  logic [D_WIDTH-1:0] mem_q [MAX_NOF_CHARS];

  assign msg_len = LEN_W'(bus.key_N) * LEN_W'(bus.key_M);
  assign reject  = (bus.key_N == '0) || (bus.key_M == '0) ||
                   (msg_len != LEN_W'(wr_ptr_q)) || ovf_q;

  // Both modes walk an inner counter along a stride and an outer counter as
  // offset: index = base + outer, with base advancing by the stride.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    ovf_d        = ovf_q;
    err_d        = 1'b0;
    inner_d      = inner_q;
    outer_d      = outer_q;
    base_d       = base_q;
    stride_d     = stride_q;
    inner_last_d = inner_last_q;
    outer_last_d = outer_last_q;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    rd_idx       = '0;

    case (state_q)
      S_LOAD: begin
        if (bus.valid_i) begin
          if (bus.data_i != START_TOKEN) begin
            if (wr_ptr_q == ptr_t'(MAX_NOF_CHARS)) begin
              ovf_d = 1'b1;
            end else begin
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
          end else begin
            wr_ptr_d = '0;
            ovf_d    = 1'b0;
            if (reject) begin
              err_d = 1'b1;
            end else begin
              state_d = S_OUT;
              rd_en   = 1'b1;
              inner_d = '0;
              outer_d = '0;
              base_d  = '0;
              if (bus.mode_i) begin
                stride_d     = ptr_t'(bus.key_N);
                inner_last_d = ptr_t'(bus.key_M) - ptr_t'(1);
                outer_last_d = ptr_t'(bus.key_N) - ptr_t'(1);
              end else begin
                stride_d     = ptr_t'(bus.key_M);
                inner_last_d = ptr_t'(bus.key_N) - ptr_t'(1);
                outer_last_d = ptr_t'(bus.key_M) - ptr_t'(1);
              end
            end
          end
        end
      end

      S_OUT: begin
        if (inner_q == inner_last_q) begin
          if (outer_q == outer_last_q) begin
            state_d = S_LOAD;
          end else begin
            rd_en   = 1'b1;
            inner_d = '0;
            base_d  = '0;
            outer_d = outer_q + ptr_t'(1);
            rd_idx  = outer_q + ptr_t'(1);
          end
        end else begin
          rd_en   = 1'b1;
          inner_d = inner_q + ptr_t'(1);
          base_d  = base_q + stride_q;
          rd_idx  = base_q + stride_q + outer_q;
        end
      end

      default: state_d = S_LOAD;
    endcase

    data_d = rd_en ? mem_q[rd_idx] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LOAD;
      wr_ptr_q     <= '0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      data_q       <= '0;
      inner_q      <= '0;
      outer_q      <= '0;
      base_q       <= '0;
      stride_q     <= '0;
      inner_last_q <= '0;
      outer_last_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
      data_q       <= data_d;
      inner_q      <= inner_d;
      outer_q      <= outer_d;
      base_q       <= base_d;
      stride_q     <= stride_d;
      inner_last_q <= inner_last_d;
      outer_last_q <= outer_last_d;
    end
  end

  // Message storage carries no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.data_i;
    end
  end

  assign bus.busy    = (state_q == S_OUT);
  assign bus.valid_o = (state_q == S_OUT);
  assign bus.data_o  = data_q;
  assign bus.err_o   = err_q;
endmodule

// File: tb/tb_scytale_codec.sv
// Directed bench for scytale_codec: a reference permutation model fills a
// scoreboard at each token, and the streamed output is popped and compared.
module tb_scytale_codec;
  localparam logic [7:0] START_TOKEN = 8'hFA;

  typedef logic [7:0] char_q_t [$];

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  logic [7:0] sb[$];
  logic [7:0] got_q[$];

  scytale_codec_if #(.D_WIDTH(8), .KEY_WIDTH(8)) bus ();

  scytale_codec #(
    .D_WIDTH      (8),
    .KEY_WIDTH    (8),
    .MAX_NOF_CHARS(50),
    .START_TOKEN  (START_TOKEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic v);
    bus.data_i  = d;
    bus.valid_i = v;
    tick();
  endtask

  function automatic char_q_t str2q(input string s);
    char_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic sendMessage(input char_q_t msg);
    foreach (msg[i]) applyStimulus(msg[i], 1'b1);
  endtask

  // Reference transposition written directly from the index formulas.
  task automatic pushExpected(input char_q_t msg, input logic mode, input int n, input int m);
    if (mode) begin
      for (int k = 0; k < n; k++)
        for (int i = 0; i < m; i++) sb.push_back(msg[i*n + k]);
    end else begin
      for (int i = 0; i < m; i++)
        for (int k = 0; k < n; k++) sb.push_back(msg[k*m + i]);
    end
  endtask

  task automatic sendToken(input logic mode, input logic [7:0] n, input logic [7:0] m);
    bus.mode_i = mode;
    bus.key_N  = n;
    bus.key_M  = m;
    applyStimulus(START_TOKEN, 1'b1);
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
  endtask

  task automatic collectOutput(input string tag, input int limit, input bit junk);
    int cnt = 0;
    got_q.delete();
    while (sb.size() > 0 && cnt < limit) begin
      checkOutput({tag, "/busy"}, 32'(bus.busy), 32'd1);
      checkOutput({tag, "/valid"}, 32'(bus.valid_o), 32'd1);
      checkOutput({tag, "/err"}, 32'(bus.err_o), 32'd0);
      checkOutput({tag, "/data"}, 32'(bus.data_o), 32'(sb.pop_front()));
      got_q.push_back(bus.data_o);
      if (junk) begin
        bus.valid_i = 1'b1;
        bus.data_i  = (cnt % 2 == 1) ? START_TOKEN : 8'($urandom_range(0, 249));
        bus.mode_i  = 1'($urandom_range(0, 1));
        bus.key_N   = 8'($urandom_range(0, 7));
        bus.key_M   = 8'($urandom_range(0, 7));
      end
      tick();
      cnt++;
    end
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    if (cnt < limit) begin
      checkOutput({tag, "/end_busy"}, 32'(bus.busy), 32'd0);
      checkOutput({tag, "/end_valid"}, 32'(bus.valid_o), 32'd0);
      checkOutput({tag, "/end_data"}, 32'(bus.data_o), 32'd0);
      checkOutput({tag, "/end_err"}, 32'(bus.err_o), 32'd0);
    end
  endtask

  task automatic expectReject(input string tag);
    checkOutput({tag, "/err_t1"}, 32'(bus.err_o), 32'd1);
    checkOutput({tag, "/busy_t1"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "/valid_t1"}, 32'(bus.valid_o), 32'd0);
    checkOutput({tag, "/data_t1"}, 32'(bus.data_o), 32'd0);
    tick();
    checkOutput({tag, "/err_t2"}, 32'(bus.err_o), 32'd0);
    checkOutput({tag, "/busy_t2"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "/valid_t2"}, 32'(bus.valid_o), 32'd0);
  endtask

  initial begin
    char_q_t msg;
    char_q_t orig;
    tests_run    = 0;
    tests_failed = 0;
    clk          = 1'b0;
    rst          = 1'b1;
    bus.data_i   = '0;
    bus.valid_i  = 1'b0;
    bus.mode_i   = 1'b0;
    bus.key_N    = '0;
    bus.key_M    = '0;

    #12;
    checkOutput("reset/busy", 32'(bus.busy), 32'd0);
    checkOutput("reset/valid", 32'(bus.valid_o), 32'd0);
    checkOutput("reset/data", 32'(bus.data_o), 32'd0);
    checkOutput("reset/err", 32'(bus.err_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Decrypt
    msg = str2q("ACEBDF");
    sendMessage(msg);
    pushExpected(msg, 1'b0, 2, 3);
    sendToken(1'b0, 8'd2, 8'd3);
    collectOutput("decrypt", 1000, 1'b0);

    // Encrypt, then decrypt the ciphertext back to the original
    orig = str2q("ABCDEF");
    sendMessage(orig);
    pushExpected(orig, 1'b1, 2, 3);
    sendToken(1'b1, 8'd2, 8'd3);
    collectOutput("encrypt", 1000, 1'b0);
    msg = got_q;
    sendMessage(msg);
    foreach (orig[i]) sb.push_back(orig[i]);
    sendToken(1'b0, 8'd2, 8'd3);
    collectOutput("roundtrip", 1000, 1'b0);

    // Length error followed by a good message
    sendMessage(str2q("ABCDE"));
    sendToken(1'b0, 8'd2, 8'd3);
    expectReject("len_err");
    msg = str2q("ACEBDF");
    sendMessage(msg);
    pushExpected(msg, 1'b0, 2, 3);
    sendToken(1'b0, 8'd2, 8'd3);
    collectOutput("after_err", 1000, 1'b0);

    // Zero keys and a product that only fits at double width
    sendToken(1'b0, 8'd0, 8'd5);
    expectReject("n_zero");
    sendToken(1'b1, 8'd3, 8'd0);
    expectReject("m_zero");
    sendToken(1'b0, 8'd16, 8'd16);
    expectReject("wide_len");

    // Single-character message
    msg = str2q("Q");
    sendMessage(msg);
    pushExpected(msg, 1'b1, 1, 1);
    sendToken(1'b1, 8'd1, 8'd1);
    collectOutput("len1", 1000, 1'b0);

    // Overflow rejected, then a full-depth message
    msg.delete();
    for (int i = 0; i < 51; i++) msg.push_back(8'(i + 1));
    sendMessage(msg);
    sendToken(1'b0, 8'd5, 8'd10);
    expectReject("overflow");
    msg.delete();
    for (int i = 0; i < 50; i++) msg.push_back(8'(i*3 + 7));
    sendMessage(msg);
    pushExpected(msg, 1'b0, 5, 10);
    sendToken(1'b0, 8'd5, 8'd10);
    collectOutput("full", 1000, 1'b0);

    // Input traffic while busy must not disturb the stream
    msg = str2q("ACEBDF");
    sendMessage(msg);
    pushExpected(msg, 1'b0, 2, 3);
    sendToken(1'b0, 8'd2, 8'd3);
    collectOutput("busy_junk", 1000, 1'b1);
    msg.delete();
    for (int i = 0; i < 20; i++) msg.push_back(8'($urandom_range(0, 249)));
    sendMessage(msg);
    pushExpected(msg, 1'b1, 4, 5);
    sendToken(1'b1, 8'd4, 8'd5);
    collectOutput("after_junk", 1000, 1'b0);

    // Reset during the third output cycle
    msg = str2q("ACEBDF");
    sendMessage(msg);
    pushExpected(msg, 1'b0, 2, 3);
    sendToken(1'b0, 8'd2, 8'd3);
    collectOutput("pre_reset", 2, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midrst/busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst/valid", 32'(bus.valid_o), 32'd0);
    checkOutput("midrst/data", 32'(bus.data_o), 32'd0);
    checkOutput("midrst/err", 32'(bus.err_o), 32'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    msg = str2q("ACEBDF");
    sendMessage(msg);
    pushExpected(msg, 1'b0, 2, 3);
    sendToken(1'b0, 8'd2, 8'd3);
    collectOutput("post_reset", 1000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
